// File: rtl/and7_match_qualifier.sv
// Synchronized, debounced 7-input AND qualifier with rise/fall pulses and a saturating hit counter.
// The filter FSM, pulses and counter advance on SP; the synchronizers run on every CK edge.
module and7_match_qualifier #(
    parameter int FILTER      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             CK,
    input  logic             CDN,
    input  logic             SP,
    input  logic             CLRH,
    input  logic             A0,
    input  logic             A1,
    input  logic             A2,
    input  logic             A3,
    input  logic             A4,
    input  logic             A5,
    input  logic             A6,
    output logic             Z0,
    output logic             ZR,
    output logic             ZF,
    output logic [CNT_W-1:0] HITS,
    output logic             SAT
);

    typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} state_t;

    if (FILTER < 1 || FILTER > 15 || (SYNC_STAGES != 1 && SYNC_STAGES != 2) ||
        CNT_W < 2 || CNT_W > 16) begin : g_bad_cfg
        $error("and7_match_qualifier: parameter out of legal range");
    end

    logic [6:0] a_in;
    logic [6:0] sync_q [SYNC_STAGES];
    logic       t;

    assign a_in = {A6, A5, A4, A3, A2, A1, A0};

    // NOTE: non-blocking assignments make each stage take the previous stage's old value,
    // so the chain really is SYNC_STAGES flops deep regardless of statement order.
    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= a_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign t = &sync_q[SYNC_STAGES-1];

    state_t           state;
    logic [3:0]       fcnt;
    logic [4:0]       fcnt_inc;
    logic             filter_done;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] hits_inc;

    // fcnt is 0 in IDLE/ACTIVE, so one compare covers both the FILTER=1 shortcut and the counted path.
    assign fcnt_inc    = {1'b0, fcnt} + 5'd1;
    assign filter_done = (fcnt_inc == 5'(FILTER));
    assign rise        = SP && !Z0 && t && filter_done;
    assign fall        = SP && Z0 && !t && filter_done;
    assign hits_inc    = HITS + 1'b1;

    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state <= IDLE;
            fcnt  <= '0;
            Z0    <= 1'b0;
            ZR    <= 1'b0;
            ZF    <= 1'b0;
            HITS  <= '0;
            SAT   <= 1'b0;
        end else begin
            ZR <= rise;
            ZF <= fall;

            if (SP) begin
                case (state)
                    IDLE: begin
                        if (t) begin
                            if (filter_done) begin
                                state <= ACTIVE;
                                Z0    <= 1'b1;
                            end else begin
                                state <= ARMING;
                                fcnt  <= 4'd1;
                            end
                        end
                    end
                    ARMING: begin
                        if (!t) begin
                            state <= IDLE;
                            fcnt  <= '0;
                        end else if (filter_done) begin
                            state <= ACTIVE;
                            fcnt  <= '0;
                            Z0    <= 1'b1;
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                    ACTIVE: begin
                        if (!t) begin
                            if (filter_done) begin
                                state <= IDLE;
                                Z0    <= 1'b0;
                            end else begin
                                state <= RELEASING;
                                fcnt  <= 4'd1;
                            end
                        end
                    end
                    RELEASING: begin
                        if (t) begin
                            state <= ACTIVE;
                            fcnt  <= '0;
                        end else if (filter_done) begin
                            state <= IDLE;
                            fcnt  <= '0;
                            Z0    <= 1'b0;
                        end else begin
                            fcnt <= fcnt + 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        fcnt  <= '0;
                        Z0    <= 1'b0;
                    end
                endcase
            end

            // Clear beats a coincident rise; rise already implies SP.
            if (CLRH) begin
                HITS <= '0;
                SAT  <= 1'b0;
            end else if (rise && !(&HITS)) begin
                HITS <= hits_inc;
                SAT  <= &hits_inc;
            end
        end
    end

endmodule

// File: tb/tb_and7_match_qualifier.sv
// Randomized bench for and7_match_qualifier: two configurations share stimulus and are
// compared every cycle against a run-length model of the persistence filter.
module tb_and7_match_qualifier;

    localparam int F0 = 4, S0 = 2, W0 = 8;
    localparam int F1 = 1, S1 = 1, W1 = 2;

    logic       ck = 1'b0;
    logic       cdn = 1'b0;
    logic       sp = 1'b0;
    logic       clrh = 1'b0;
    logic [6:0] a_vec = '0;

    logic          z0_0, zr_0, zf_0, sat_0;
    logic [W0-1:0] hits_0;
    logic          z0_1, zr_1, zf_1, sat_1;
    logic [W1-1:0] hits_1;

    always #5 ck = ~ck;

    and7_match_qualifier #(.FILTER(F0), .SYNC_STAGES(S0), .CNT_W(W0)) dut (
        .CK(ck), .CDN(cdn), .SP(sp), .CLRH(clrh),
        .A0(a_vec[0]), .A1(a_vec[1]), .A2(a_vec[2]), .A3(a_vec[3]),
        .A4(a_vec[4]), .A5(a_vec[5]), .A6(a_vec[6]),
        .Z0(z0_0), .ZR(zr_0), .ZF(zf_0), .HITS(hits_0), .SAT(sat_0)
    );

    and7_match_qualifier #(.FILTER(F1), .SYNC_STAGES(S1), .CNT_W(W1)) dut_small (
        .CK(ck), .CDN(cdn), .SP(sp), .CLRH(clrh),
        .A0(a_vec[0]), .A1(a_vec[1]), .A2(a_vec[2]), .A3(a_vec[3]),
        .A4(a_vec[4]), .A5(a_vec[5]), .A6(a_vec[6]),
        .Z0(z0_1), .ZR(zr_1), .ZF(zf_1), .HITS(hits_1), .SAT(sat_1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: T is the input AND seen SYNC edges ago; Z0 flips after FILTER consecutive
    // enabled samples that disagree with it.
    int         filt [2] = '{F0, F1};
    int         hmax [2] = '{(1 << W0) - 1, (1 << W1) - 1};
    logic       m_z [2], m_zr [2], m_zf [2], m_sat [2];
    int         m_run [2], m_hits [2];
    logic [6:0] q0 [$];
    logic [6:0] q1 [$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_z[i] = 0; m_zr[i] = 0; m_zf[i] = 0; m_sat[i] = 0;
            m_run[i] = 0; m_hits[i] = 0;
        end
        q0 = {};
        q1 = {};
        for (int i = 0; i < S0; i++) q0.push_back(7'h00);
        for (int i = 0; i < S1; i++) q1.push_back(7'h00);
    endtask

    task automatic filt_step(input int i, input logic t);
        m_zr[i] = 0;
        m_zf[i] = 0;
        if (sp) begin
            if (t != m_z[i]) begin
                m_run[i]++;
                if (m_run[i] == filt[i]) begin
                    m_z[i] = t;
                    m_run[i] = 0;
                    if (t) m_zr[i] = 1; else m_zf[i] = 1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (clrh) m_hits[i] = 0;
        else if (m_zr[i] && m_hits[i] < hmax[i]) m_hits[i]++;
        m_sat[i] = (m_hits[i] == hmax[i]);
    endtask

    task automatic model_edge();
        logic t0, t1;
        t0 = &q0[0];
        t1 = &q1[0];
        void'(q0.pop_front());
        void'(q1.pop_front());
        q0.push_back(a_vec);
        q1.push_back(a_vec);
        filt_step(0, t0);
        filt_step(1, t1);
    endtask

    task automatic compare_all();
        check("z0_a",   16'(z0_0),   16'(m_z[0]));
        check("zr_a",   16'(zr_0),   16'(m_zr[0]));
        check("zf_a",   16'(zf_0),   16'(m_zf[0]));
        check("hits_a", 16'(hits_0), 16'(m_hits[0]));
        check("sat_a",  16'(sat_0),  16'(m_sat[0]));
        check("z0_b",   16'(z0_1),   16'(m_z[1]));
        check("zr_b",   16'(zr_1),   16'(m_zr[1]));
        check("zf_b",   16'(zf_1),   16'(m_zf[1]));
        check("hits_b", 16'(hits_1), 16'(m_hits[1]));
        check("sat_b",  16'(sat_1),  16'(m_sat[1]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs_a"}, {11'd0, z0_0, zr_0, zf_0, sat_0, 1'b0} | 16'(hits_0), 16'h0);
        check({tag, "_outs_b"}, {11'd0, z0_1, zr_1, zf_1, sat_1, 1'b0} | 16'(hits_1), 16'h0);
    endtask

    task automatic step();
        @(posedge ck);
        model_edge();
        @(negedge ck);
        compare_all();
    endtask

    // Assert CDN between edges, check outputs clear at once, then release on a later negedge.
    task automatic async_reset(input string tag);
        #2 cdn = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        @(negedge ck);
        cdn = 1'b1;
    endtask

    // From an idle, freshly reset machine with all inputs high: Z0 must appear on edge S0+F0.
    task automatic latency_run(input string tag);
        a_vec = 7'h7f;
        sp = 1'b1;
        clrh = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) check({tag, "_e5_z0"}, 16'(z0_0), 16'd0);
            if (e == 6) begin
                check({tag, "_e6_z0"}, 16'(z0_0), 16'd1);
                check({tag, "_e6_zr"}, 16'(zr_0), 16'd1);
                check({tag, "_e6_hits"}, 16'(hits_0), 16'd1);
            end
            if (e == 7) check({tag, "_e7_zr"}, 16'(zr_0), 16'd0);
        end
    endtask

    initial begin
        int hold;
        model_reset();
        @(negedge ck);
        check_all_zero("reset");
        @(negedge ck);
        cdn = 1'b1;

        latency_run("rise");

        // Fall with a release glitch: 3 low samples then high keeps Z0, 4 low samples drop it.
        a_vec = 7'h77;
        for (int i = 0; i < 3; i++) step();
        a_vec = 7'h7f;
        for (int i = 0; i < 6; i++) step();
        check("glitch_hold_z0", 16'(z0_0), 16'd1);
        a_vec = 7'h7e;
        for (int i = 0; i < 8; i++) step();
        check("fall_z0", 16'(z0_0), 16'd0);

        // Reset mid-ARMING (two edges into the term being high) and mid-ACTIVE.
        a_vec = 7'h7f;
        for (int i = 0; i < 4; i++) step();
        async_reset("rst_arming");
        a_vec = 7'h00;
        for (int i = 0; i < 3; i++) step();
        latency_run("rerise1");
        async_reset("rst_active");
        latency_run("rerise2");

        // Randomized traffic: held input patterns, sparse SP drops and CLRH, one mid-run reset.
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 7);
                if ($urandom_range(0, 99) < 60) a_vec = 7'h7f;
                else a_vec = 7'h7f & ~(7'd1 << $urandom_range(0, 6)) & 7'($urandom | 32'h55);
            end
            hold--;
            sp   = ($urandom_range(0, 7) != 0);
            clrh = ($urandom_range(0, 39) == 0);
            step();
            if (c == 750) async_reset("rst_random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/and7_match_qualifier.md
Name: and7_match_qualifier

Overview:
- Sequential qualifier stage for a 7-input AND product term in the schematic macro library.
- Synchronizes seven asynchronous term inputs and forms their AND.
- Debounces that AND result with a programmable persistence filter.
- Produces a qualified level, one-cycle rise and fall pulses, and a saturating hit counter for downstream control logic.

Parameters:
- FILTER, 4, consecutive enabled cycles the raw term must hold a new value before Z0 follows it; legal range 1..15.
- SYNC_STAGES, 2, synchronizer depth per input; legal values 1 or 2.
- CNT_W, 8, width of the hit counter HITS; legal range 2..16.

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- CDN  input  1  asynchronous active-low reset; clears all state.
- SP  input  1  clock enable for the filter, the pulses and the counter (not for the synchronizers).
- CLRH  input  1  synchronous clear of HITS and SAT.
- A0..A6  input  1 each  product-term inputs, asynchronous to CK.
- Z0  output  1  qualified AND of A0..A6.
- ZR  output  1  one-cycle pulse on the rising edge of Z0.
- ZF  output  1  one-cycle pulse on the falling edge of Z0.
- HITS  output  CNT_W  count of Z0 rising events, saturating.
- SAT  output  1  high while HITS equals all-ones.

Behaviour:
- Reset: CDN low asynchronously clears every flop to 0, including synchronizer flops, filter counter and state. Outputs Z0, ZR, ZF, HITS and SAT are all 0. State is IDLE. The first active edge after CDN rises is ordinary.
- Synchronizers: each Ai passes through SYNC_STAGES flops on every CK edge, independent of SP. The raw term T is the AND of the last-stage flops and is purely combinational from those registers.
- State machine: states IDLE, ARMING, ACTIVE, RELEASING. A 4-bit counter fcnt is used only in ARMING and RELEASING. The machine advances only on edges with SP=1; with SP=0, state, fcnt, Z0 and HITS hold.
- IDLE (Z0=0):
  - T=1 and FILTER=1: go to ACTIVE.
  - T=1 and FILTER>1: go to ARMING with fcnt=1.
  - Otherwise stay in IDLE.
- ARMING (Z0=0):
  - T=0: go to IDLE, fcnt=0. A glitch restarts the count.
  - T=1: fcnt+1. When the increment reaches FILTER, go to ACTIVE.
- ACTIVE (Z0=1): mirror of IDLE, using T=0 and RELEASING.
- RELEASING (Z0=1): mirror of ARMING. T=1 returns to ACTIVE; FILTER consecutive T=0 samples go to IDLE.
- Z0 is registered. It is 1 exactly in ACTIVE and RELEASING.
- Latency with SP held at 1: Z0 changes on edge number SYNC_STAGES+FILTER, counting the first edge that samples the new A value as edge 1.
- ZR and ZF:
  - Registered and asserted on the same edge that Z0 changes, for exactly one cycle.
  - An edge with SP=0 forces both to 0.
  - They are never both 1.
- HITS and SAT:
  - HITS increments on each edge where ZR is being set.
  - HITS saturates at 2^CNT_W-1 and does not wrap.
  - SAT is registered, equal to (HITS == all-ones), and updates on the same edge as HITS.
- CLRH:
  - When CLRH=1 on an edge, HITS and SAT go to 0 regardless of SP.
  - If CLRH and a rise event occur on the same edge, the clear wins and HITS=0. ZR still pulses.
- Reset mid-operation: any state, any fcnt value and any pending pulse is discarded immediately. No pulse is emitted on reset release.
- Out-of-range parameters are a configuration error, flagged by a simulation-time check. Synthesis behaviour is undefined for them.

Test Plan:
- Basic rise: defaults, SP=1, all A set to 1 before edge 1 and held -> Z0, ZR and HITS=1 all appear after edge 6. ZR is low after edge 7.
- Glitch rejection: defaults, A3 low for one cycle while in ARMING (synchronized T sequence 1,1,0,1,1,1,1) -> no ZR. Z0 rises only after the 4th consecutive T=1 following the drop.
- Fall and release glitch: from ACTIVE, T=0 for 3 cycles then 1 -> Z0 stays 1 with no ZF. Then T=0 for 4 cycles -> Z0=0 with a single ZF pulse.
- Enable gating: SP toggled 1,0,1,0 while T=1 -> fcnt advances only on SP=1 edges. Z0 rises after the 4th enabled sample. No ZR appears on any SP=0 edge.
- Saturation and clear: CNT_W=2, five rise/fall cycles -> HITS goes 1,2,3,3,3 with SAT=1 from the 3rd rise. CLRH coincident with the 6th ZR -> HITS=0, SAT=0, ZR=1.
- Async reset: CDN pulled low mid-ARMING and mid-ACTIVE, between clock edges -> all outputs 0 immediately, without waiting for a clock edge. After release, the full SYNC_STAGES+FILTER latency is required again.
